dm_bytelane: RTL and testbench
==============================

# dm_bytelane

Parametrised byte-addressed data memory for the MIPS core, replacing the fixed 1 KiB word-only memory. Adds:
- byte, halfword and word stores and loads, with sign or zero extension;
- alignment checking;
- a configurable access latency behind a valid/ready request and response handshake;
- a hardware clear sweep after reset.

It sits between the MEM stage and the data storage; the core stalls on `req_ready`/`rsp_valid`.

## Interface
- `ADDR_WIDTH`, default 10: byte-address bits; capacity is 2^ADDR_WIDTH bytes, stored as 2^(ADDR_WIDTH-2) 32-bit words. Must be at least 3.
- `WAIT_CYCLES`, default 0: extra wait-state cycles inserted before each access.
- `CLEAR_ON_RESET`, default 1: 1 runs the zero-fill sweep after reset; 0 skips it (contents then undefined).

Ports (one clock `clk`; reset `rst_n` is asynchronous, active-low):
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request this cycle.
- `req_we` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_signed` input 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr` input ADDR_WIDTH: byte address.
- `req_wdata` input 32: store data, LSB-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid` output 1: one-cycle response pulse.
- `rsp_rdata` output 32: load result; 0 for stores and errors.
- `rsp_err` output 1: misaligned or illegal-size request; qualified by `rsp_valid`.

## Operation
- **Storage:** little-endian. The byte at address a is word a[ADDR_WIDTH-1:2], lane a[1:0].
- **Stores:**
  - Byte: writes lane a[1:0].
  - Half: writes lanes a[1:0] and a[1:0]+1, with wdata[7:0] at the lower address.
  - Word: writes all four lanes, with wdata[7:0] at a.
- **Loads:** return the addressed byte, half or word, right-justified and extended according to `req_signed`. For word loads `req_signed` is ignored.
- **Errors:**
  - Triggered by: half with a[0]=1, word with a[1:0]!=0, or size 11.
  - Effect: no memory write; `rsp_err`=1, `rsp_rdata`=0.
  - The error response uses the same latency as a good access.
- **States:**
  - CLEAR:
    - Entered on reset if `CLEAR_ON_RESET`=1, otherwise reset goes to IDLE.
    - A word counter zeroes one word per cycle, from 0 to 2^(ADDR_WIDTH-2)-1, then moves to IDLE.
    - `req_ready`=0 throughout.
  - IDLE:
    - `req_ready`=1.
    - `req_valid`&`req_ready` latches all `req_*` fields.
    - Goes to WAIT if `WAIT_CYCLES`>0, else to ACCESS.
  - WAIT: a down-counter loaded with `WAIT_CYCLES`; `req_ready`=0; moves to ACCESS when the counter reaches 1.
  - ACCESS:
    - `req_ready`=0.
    - On the exit edge, the write is committed, `rsp_rdata`/`rsp_err` are registered and `rsp_valid` is set.
    - Moves to IDLE.
- **Inputs while busy:** `req_*` inputs are ignored outside IDLE. The latched copy is used, so the requester may change its inputs after acceptance.

## Timing
- Reset (asynchronous, immediate):
  - `req_ready`=0 when `CLEAR_ON_RESET`=1, else 1.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - All counters 0.
- Reset mid-request: the pending request is dropped, no write occurs and no response is issued. Writes are single-edge, so no partial word is possible.
- Latency, with acceptance in cycle 0:
  - WAIT occupies cycles 1..W.
  - ACCESS is cycle W+1.
  - `rsp_valid`=1 in cycle W+2, for exactly one cycle.
- Throughput: in cycle W+2 the block is in IDLE with `req_ready`=1, so the next request may be accepted in the same cycle as the response. Sustained rate is one access per W+2 cycles.
- Load after store to the same address: the load returns the new data, since the store commits before the next acceptance.
- Clear duration: 2^(ADDR_WIDTH-2) cycles after reset deasserts (256 cycles at the default). `req_ready` rises in the following cycle.
- `rsp_rdata`/`rsp_err` hold their values until the next response; they are meaningful only while `rsp_valid`=1.

## Structure
- Shared package `dm_pkg`:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state enum CLEAR/IDLE/WAIT/ACCESS;
  - a function computing the misalignment flag.
- Sub-module `dm_lane_align` (combinational):
  - maps size and a[1:0] to a 4-bit byte-enable and lane-shifted write data;
  - selects and extends read data.
- Top level holds the FSM, counters, request latch and word array with per-lane write enables.

## Test plan
- Reset with `CLEAR_ON_RESET`=1, ADDR_WIDTH=10 -> `req_ready` low for 256 cycles; afterwards a word load of 0x3FC returns 0x00000000.
- Word store 0xDEADBEEF at 0x010, then byte loads at 0x010..0x013 -> EF, BE, AD, DE. A signed byte load of 0x013 returns 0xFFFFFFDE; an unsigned one returns 0x000000DE.
- Half store 0x8001 at 0x022, then signed and unsigned half loads at 0x022 -> 0xFFFF8001 and 0x00008001. A word load at 0x020 shows the lower half unchanged at 0.
- Word store at 0x011 and half load at 0x013 -> `rsp_err`=1, `rsp_rdata`=0, and a word load at 0x010 shows memory unchanged.
- With `WAIT_CYCLES`=3, back-to-back loads -> `rsp_valid` in cycle 5 after each acceptance. A new acceptance happens in the response cycle, giving one access per 5 cycles.
- `rst_n` asserted during WAIT of a store 0x12345678 to 0x040 -> no response; after the clear sweep, 0x040 reads 0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the byte-addressed data memory: size codes, FSM states and
// the alignment check used by both the datapath and the response logic.
package dm_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      StClear,
      StIdle,
      StWait,
      StAccess
   } dm_state_e;

   // Illegal size (2'b11) is folded into the misalignment flag.
   function automatic logic dm_misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lane[0];
         SZ_WORD: bad = (lane != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Lane steering for the data memory: byte enables and shifted store data on the way in,
// lane select plus sign/zero extension on the way out.
module dm_lane_align
   import dm_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        sign_ext,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wdata_sh,
   output logic [31:0] rdata
);

   logic [31:0] rshift;

   always_comb begin
      be       = 4'b0000;
      wdata_sh = wdata << {lane, 3'b000};
      rshift   = rword >> {lane, 3'b000};
      rdata    = '0;
      case (size)
         SZ_BYTE: begin
            be    = 4'b0001 << lane;
            rdata = {{24{sign_ext & rshift[7]}}, rshift[7:0]};
         end
         SZ_HALF: begin
            be    = 4'b0011 << lane;
            rdata = {{16{sign_ext & rshift[15]}}, rshift[15:0]};
         end
         SZ_WORD: begin
            be    = 4'b1111;
            rdata = rword;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dm_bytelane.sv
// Byte-addressed data memory with valid/ready request, one-cycle response pulse,
// configurable wait states and an optional zero-fill sweep after reset.
module dm_bytelane
   import dm_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned WAIT_CYCLES    = 0,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err
);

   localparam int unsigned WordAw = ADDR_WIDTH - 2;
   localparam int unsigned Words  = 2 ** WordAw;
   localparam int unsigned WaitW  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

   logic [31:0] mem [Words];

   dm_state_e             state_q;
   logic [WordAw-1:0]     clr_cnt_q;
   logic [WaitW-1:0]      wait_cnt_q;
   logic                  we_q;
   logic [1:0]            size_q;
   logic                  signed_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;

   logic [WordAw-1:0] word_idx;
   logic [31:0]       rword;
   logic [3:0]        be;
   logic [31:0]       wdata_sh;
   logic [31:0]       rdata_ext;
   logic              err;

   assign word_idx = addr_q[ADDR_WIDTH-1:2];
   assign rword    = mem[word_idx];
   assign err      = dm_misaligned(size_q, addr_q[1:0]);

   dm_lane_align u_lane_align (
      .size     (size_q),
      .lane     (addr_q[1:0]),
      .sign_ext (signed_q),
      .wdata    (wdata_q),
      .rword    (rword),
      .be       (be),
      .wdata_sh (wdata_sh),
      .rdata    (rdata_ext)
   );

   // Storage has no reset; the clear sweep and committed stores are its only writers.
   always_ff @(posedge clk) begin
      if (state_q == StClear) begin
         mem[clr_cnt_q] <= '0;
      end else if (state_q == StAccess && we_q && !err) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[word_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= CLEAR_ON_RESET ? StClear : StIdle;
         req_ready  <= !CLEAR_ON_RESET;
         clr_cnt_q  <= '0;
         wait_cnt_q <= '0;
         we_q       <= 1'b0;
         size_q     <= SZ_BYTE;
         signed_q   <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state_q)
            StClear: begin
               if (clr_cnt_q == '1) begin
                  clr_cnt_q <= '0;
                  state_q   <= StIdle;
                  req_ready <= 1'b1;
               end else begin
                  clr_cnt_q <= clr_cnt_q + 1'b1;
               end
            end
            StIdle: begin
               if (req_valid && req_ready) begin
                  we_q      <= req_we;
                  size_q    <= req_size;
                  signed_q  <= req_signed;
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  req_ready <= 1'b0;
                  if (WAIT_CYCLES > 0) begin
                     state_q    <= StWait;
                     wait_cnt_q <= WaitW'(WAIT_CYCLES);
                  end else begin
                     state_q <= StAccess;
                  end
               end
            end
            StWait: begin
               if (wait_cnt_q == WaitW'(1)) begin
                  wait_cnt_q <= '0;
                  state_q    <= StAccess;
               end else begin
                  wait_cnt_q <= wait_cnt_q - 1'b1;
               end
            end
            StAccess: begin
               state_q   <= StIdle;
               req_ready <= 1'b1;
               rsp_valid <= 1'b1;
               rsp_err   <= err;
               rsp_rdata <= (err || we_q) ? 32'h0 : rdata_ext;
            end
            default: begin
               state_q   <= StIdle;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dm_bytelane.sv
// Scoreboard bench for dm_bytelane: expected responses are queued at request time and
// checked (data, error flag, latency) when the response pulse appears.
module tb_dm_bytelane;

   localparam int unsigned AW = 10;
   localparam int unsigned W  = 3;
   localparam logic [1:0]  B  = 2'b00;
   localparam logic [1:0]  H  = 2'b01;
   localparam logic [1:0]  WD = 2'b10;
   localparam logic [1:0]  IL = 2'b11;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [1:0]    req_size = 2'b00;
   logic          req_signed = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [31:0]   req_wdata = '0;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;

   int cyc = 0;
   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   dm_bytelane #(
      .ADDR_WIDTH     (AW),
      .WAIT_CYCLES    (W),
      .CLEAR_ON_RESET (1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         if (exp_q.size() == 0) begin
            chk("spurious_rsp", {31'b0, rsp_valid}, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, mon_e.rdata);
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
            chk("latency", 32'(cyc - mon_e.acc), 32'(W + 2));
         end
      end
   end

   // Called at a negedge; returns at a later negedge with req_valid low.
   task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [AW-1:0] a, input logic [31:0] wd,
                        input logic eerr, input logic [31:0] erd, output int acc);
      int n = 0;
      while (!req_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) chk("ready_timeout", {31'b0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      acc        = cyc;
      exp_q.push_back('{err: eerr, rdata: erd, acc: cyc});
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_size   = 2'($urandom);
      req_signed = 1'($urandom);
      req_addr   = AW'($urandom);
      req_wdata  = $urandom;
      @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
   endtask

   task automatic clear_sweep(input string tag);
      int n = 0;
      rst_n = 1'b1;
      while (!req_ready && n < 2000) begin
         n++;
         @(negedge clk);
      end
      chk(tag, 32'(n), 32'd256);
   endtask

   initial begin
      int a0, a1;
      #1;
      chk("rst_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", {31'b0, rsp_err}, 32'd0);
      @(negedge clk);
      clear_sweep("clear_cycles");

      issue(1'b0, WD, 1'b0, 10'h3FC, 32'h0, 1'b0, 32'h0000_0000, a0);

      issue(1'b1, WD, 1'b0, 10'h010, 32'hDEADBEEF, 1'b0, 32'h0, a0);
      issue(1'b0, B, 1'b0, 10'h010, 32'h0, 1'b0, 32'h0000_00EF, a0);
      issue(1'b0, B, 1'b0, 10'h011, 32'h0, 1'b0, 32'h0000_00BE, a0);
      issue(1'b0, B, 1'b0, 10'h012, 32'h0, 1'b0, 32'h0000_00AD, a0);
      issue(1'b0, B, 1'b0, 10'h013, 32'h0, 1'b0, 32'h0000_00DE, a0);
      issue(1'b0, B, 1'b1, 10'h013, 32'h0, 1'b0, 32'hFFFF_FFDE, a0);
      issue(1'b0, B, 1'b1, 10'h011, 32'h0, 1'b0, 32'hFFFF_FFBE, a0);
      issue(1'b0, H, 1'b1, 10'h012, 32'h0, 1'b0, 32'hFFFF_DEAD, a0);

      issue(1'b1, H, 1'b0, 10'h022, 32'hFFFF_8001, 1'b0, 32'h0, a0);
      issue(1'b0, H, 1'b1, 10'h022, 32'h0, 1'b0, 32'hFFFF_8001, a0);
      issue(1'b0, H, 1'b0, 10'h022, 32'h0, 1'b0, 32'h0000_8001, a0);
      issue(1'b0, WD, 1'b1, 10'h020, 32'h0, 1'b0, 32'h8001_0000, a0);

      issue(1'b1, WD, 1'b0, 10'h011, 32'h1111_1111, 1'b1, 32'h0, a0);
      issue(1'b0, H, 1'b0, 10'h013, 32'h0, 1'b1, 32'h0, a0);
      issue(1'b1, IL, 1'b0, 10'h010, 32'h2222_2222, 1'b1, 32'h0, a0);
      issue(1'b0, WD, 1'b0, 10'h010, 32'h0, 1'b0, 32'hDEAD_BEEF, a0);

      issue(1'b1, B, 1'b0, 10'h012, 32'h5555_55AA, 1'b0, 32'h0, a0);
      issue(1'b0, WD, 1'b0, 10'h010, 32'h0, 1'b0, 32'hDEAA_BEEF, a0);

      issue(1'b0, WD, 1'b0, 10'h020, 32'h0, 1'b0, 32'h8001_0000, a0);
      issue(1'b0, WD, 1'b0, 10'h010, 32'h0, 1'b0, 32'hDEAA_BEEF, a1);
      chk("b2b_spacing", 32'(a1 - a0), 32'(W + 2));
      drain();

      issue(1'b1, WD, 1'b0, 10'h040, 32'h1234_5678, 1'b0, 32'h0, a0);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("midrst_ready", {31'b0, req_ready}, 32'd0);
      chk("midrst_valid", {31'b0, rsp_valid}, 32'd0);
      repeat (2) @(negedge clk);
      clear_sweep("clear_cycles_2");
      issue(1'b0, WD, 1'b0, 10'h040, 32'h0, 1'b0, 32'h0000_0000, a0);
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
